// File: rtl/dcache_pkg.sv
// Shared types and helpers for the set-associative write-back data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_ALLOCATE,
    S_REFILL
  } state_e;

  localparam int unsigned LINE_W = 256;
  localparam int unsigned CPU_W  = 32;
  localparam int unsigned SEL_W  = $clog2(LINE_W / CPU_W);

  function automatic int unsigned off_w(input int unsigned line_bits);
    return $clog2(line_bits / 8);
  endfunction

  function automatic int unsigned idx_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned line_bits,
                                        input int unsigned sets);
    return addr_w - off_w(line_bits) - idx_w(sets);
  endfunction

  function automatic logic [CPU_W-1:0] word_get(input logic [LINE_W-1:0] line,
                                                input logic [SEL_W-1:0] sel);
    return line[sel*CPU_W +: CPU_W];
  endfunction

  function automatic logic [LINE_W-1:0] word_put(input logic [LINE_W-1:0] line,
                                                 input logic [SEL_W-1:0] sel,
                                                 input logic [CPU_W-1:0] word);
    logic [LINE_W-1:0] r;
    r = line;
    r[sel*CPU_W +: CPU_W] = word;
    return r;
  endfunction

endpackage

// File: rtl/dcache_assoc_ctrl_way.sv
// One cache way: tag/valid/dirty/data per set, combinational read, synchronous write.
module dcache_way_array #(
  parameter int SETS      = 32,
  parameter int IDX_W     = 5,
  parameter int TAG_W     = 22,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IDX_W-1:0]     i_idx,
  input  logic                 i_we,
  input  logic                 i_wdirty,
  input  logic [TAG_W-1:0]     i_wtag,
  input  logic [LINE_BITS-1:0] i_wline,
  output logic                 o_valid,
  output logic                 o_dirty,
  output logic [TAG_W-1:0]     o_tag,
  output logic [LINE_BITS-1:0] o_line
);

  logic [SETS-1:0]      r_valid;
  logic [SETS-1:0]      r_dirty;
  logic [TAG_W-1:0]     r_tag  [SETS];
  logic [LINE_BITS-1:0] r_data [SETS];

  // Only the status bits are reset; tag/data contents are don't-care until valid.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_we) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= i_wdirty;
    end
  end

  always_ff @(posedge clk_i) begin
    if (i_we) begin
      r_tag[i_idx]  <= i_wtag;
      r_data[i_idx] <= i_wline;
    end
  end

  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_line  = r_data[i_idx];

endmodule

// File: rtl/dcache_assoc_ctrl.sv
// N-way set-associative write-back/write-allocate D-cache controller with per-set round-robin victim.
module dcache_assoc_ctrl
  import dcache_pkg::*;
#(
  parameter int WAYS      = 2,
  parameter int SETS      = 32,
  parameter int LINE_BITS = 256,
  parameter int ADDR_W    = 32,
  parameter int WORD_W    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_W-1:0]    p1_addr_i,
  input  logic [WORD_W-1:0]    p1_data_i,
  input  logic                 p1_MemRead_i,
  input  logic                 p1_MemWrite_i,
  output logic [WORD_W-1:0]    p1_data_o,
  output logic                 p1_stall_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i,
  output logic [LINE_BITS-1:0] mem_data_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o
);

  localparam int OFF   = off_w(LINE_BITS);
  localparam int IDX   = idx_w(SETS);
  localparam int TAG   = tag_w(ADDR_W, LINE_BITS, SETS);
  localparam int SEL   = OFF - 2;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_e                     r_state, w_next;
  logic [WAY_W-1:0]           r_victim;
  logic                       r_from_ptr;
  logic [LINE_BITS-1:0]       r_fill;
  logic [SETS-1:0][WAY_W-1:0] r_ptr;

  logic [TAG-1:0] w_tag;
  logic [IDX-1:0] w_idx;
  logic [SEL-1:0] w_sel;
  logic           w_req;
  logic           w_unused_ok;

  assign w_tag       = p1_addr_i[ADDR_W-1 -: TAG];
  assign w_idx       = p1_addr_i[OFF +: IDX];
  assign w_sel       = p1_addr_i[2 +: SEL];
  assign w_req       = p1_MemRead_i | p1_MemWrite_i;
  assign w_unused_ok = &{1'b0, p1_addr_i[1:0]};

  logic [WAYS-1:0]      w_valid, w_dirty, w_hit, w_we;
  logic [TAG-1:0]       w_tagr  [WAYS];
  logic [LINE_BITS-1:0] w_liner [WAYS];
  logic [LINE_BITS-1:0] w_wline, w_hit_line;
  logic                 w_wdirty, w_hit_any, w_vic_from_ptr;
  logic [WAY_W-1:0]     w_hit_way, w_vic;

  // Refill installs a clean line; a store hit rewrites the hit line with one word replaced.
  assign w_wdirty = (r_state != S_REFILL);
  assign w_wline  = (r_state == S_REFILL) ? r_fill : word_put(w_hit_line, w_sel, p1_data_i);

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    assign w_hit[g] = w_valid[g] && (w_tagr[g] == w_tag);
    assign w_we[g]  = ((r_state == S_REFILL) && (r_victim == WAY_W'(g))) ||
                      ((r_state == S_IDLE) && p1_MemWrite_i && w_hit[g]);

    dcache_way_array #(
      .SETS(SETS), .IDX_W(IDX), .TAG_W(TAG), .LINE_BITS(LINE_BITS)
    ) u_way (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .i_idx    (w_idx),
      .i_we     (w_we[g]),
      .i_wdirty (w_wdirty),
      .i_wtag   (w_tag),
      .i_wline  (w_wline),
      .o_valid  (w_valid[g]),
      .o_dirty  (w_dirty[g]),
      .o_tag    (w_tagr[g]),
      .o_line   (w_liner[g])
    );
  end

  // Descending scans leave the lowest matching way selected.
  always_comb begin
    w_hit_any = 1'b0;
    w_hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_hit[w]) begin
        w_hit_any = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    w_vic          = r_ptr[w_idx];
    w_vic_from_ptr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!w_valid[w]) begin
        w_vic          = WAY_W'(w);
        w_vic_from_ptr = 1'b0;
      end
    end
  end

  assign w_hit_line = w_liner[w_hit_way];

  // Outputs are forced low while reset is asserted so an aborted transfer drops immediately.
  always_comb begin
    w_next       = r_state;
    p1_stall_o   = 1'b0;
    p1_data_o    = '0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    if (rst_i) begin
      case (r_state)
        S_IDLE: begin
          if (w_req && w_hit_any) begin
            p1_data_o = word_get(w_hit_line, w_sel);
          end else if (w_req) begin
            p1_stall_o = 1'b1;
            w_next     = (w_valid[w_vic] && w_dirty[w_vic]) ? S_WRITEBACK : S_ALLOCATE;
          end
        end
        S_WRITEBACK: begin
          p1_stall_o   = 1'b1;
          mem_enable_o = 1'b1;
          mem_write_o  = 1'b1;
          mem_addr_o   = {w_tagr[r_victim], w_idx, {OFF{1'b0}}};
          mem_data_o   = w_liner[r_victim];
          if (mem_ack_i) w_next = S_ALLOCATE;
        end
        S_ALLOCATE: begin
          p1_stall_o   = 1'b1;
          mem_enable_o = 1'b1;
          mem_addr_o   = {w_tag, w_idx, {OFF{1'b0}}};
          if (mem_ack_i) w_next = S_REFILL;
        end
        S_REFILL: begin
          p1_stall_o = 1'b1;
          w_next     = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_victim   <= '0;
      r_from_ptr <= 1'b0;
      r_fill     <= '0;
      r_ptr      <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && w_req && !w_hit_any) begin
        r_victim   <= w_vic;
        r_from_ptr <= w_vic_from_ptr;
      end
      if ((r_state == S_ALLOCATE) && mem_ack_i) r_fill <= mem_data_i;
      if ((r_state == S_REFILL) && r_from_ptr && (WAYS > 1))
        r_ptr[w_idx] <= r_ptr[w_idx] + 1'b1;
    end
  end

endmodule

// File: tb/tb_dcache_assoc_ctrl.sv
// Scoreboard bench for dcache_assoc_ctrl: directed requests, a latency-modelled line memory, queued expectations.
module tb_dcache_assoc_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]  p1_addr = '0, p1_wdata = '0;
  logic         p1_rd = 1'b0, p1_wr = 1'b0;
  wire  [31:0]  p1_rdata;
  wire          p1_stall;
  logic [255:0] mem_rdata = '0;
  logic         ack_model = 1'b0, ack_late = 1'b0;
  wire          mem_ack = ack_model | ack_late;
  wire  [255:0] mem_wdata;
  wire  [31:0]  mem_addr;
  wire          mem_en, mem_we;

  dcache_assoc_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .p1_addr_i     (p1_addr),
    .p1_data_i     (p1_wdata),
    .p1_MemRead_i  (p1_rd),
    .p1_MemWrite_i (p1_wr),
    .p1_data_o     (p1_rdata),
    .p1_stall_o    (p1_stall),
    .mem_data_i    (mem_rdata),
    .mem_ack_i     (mem_ack),
    .mem_data_o    (mem_wdata),
    .mem_addr_o    (mem_addr),
    .mem_enable_o  (mem_en),
    .mem_write_o   (mem_we)
  );

  typedef struct { logic is_load; logic [31:0] data; int stall; } req_exp_t;
  typedef struct { logic wr; logic [31:0] addr; int widx; logic [31:0] word; } mem_exp_t;

  req_exp_t     rq[$];
  mem_exp_t     mq[$];
  logic [255:0] mem [logic [31:0]];
  int           n_cmp = 0, n_bad = 0;
  int           lat = 10;

  function automatic logic [31:0] init_word(input logic [31:0] a, input int k);
    return {8'hA5, a[23:0]} + 32'(k);
  endfunction

  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] l;
    if (mem.exists(a)) return mem[a];
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = init_word(a, k);
    return l;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  // Memory: acks on the lat-th enabled cycle; the cycle after an ack is a turnaround cycle.
  initial begin : mem_model
    int       cnt;
    mem_exp_t e;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (ack_model) begin
        ack_model = 1'b0;
        cnt = 0;
      end else if (!mem_en) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt == lat) begin
          ack_model = 1'b1;
          if (mq.size() == 0) begin
            fail_now($sformatf("mem_unexpected addr %h wr %b", mem_addr, mem_we));
          end else begin
            e = mq.pop_front();
            chk("mem_write", {31'b0, mem_we}, {31'b0, e.wr});
            chk("mem_addr", mem_addr, e.addr);
            if (e.wr) chk("wb_word", mem_wdata[e.widx*32 +: 32], e.word);
          end
          if (mem_we) mem[mem_addr] = mem_wdata;
          else        mem_rdata = line_of(mem_addr);
        end
      end
    end
  end

  // Monitor: a request completes on the first unstalled cycle; stall cycles before it are counted.
  initial begin : monitor
    int       scnt;
    req_exp_t e;
    scnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        scnt = 0;
      end else if (p1_rd || p1_wr) begin
        if (p1_stall) begin
          scnt++;
        end else begin
          if (rq.size() == 0) begin
            fail_now($sformatf("req_unexpected addr %h", p1_addr));
          end else begin
            e = rq.pop_front();
            chk($sformatf("stall_cycles@%h", p1_addr), 32'(scnt), 32'(e.stall));
            if (e.is_load) chk($sformatf("load_data@%h", p1_addr), p1_rdata, e.data);
          end
          scnt = 0;
        end
      end
    end
  end

  task automatic exp_mem(input logic wr, input logic [31:0] a, input int widx, input logic [31:0] w);
    mem_exp_t e;
    e.wr = wr; e.addr = a; e.widx = widx; e.word = w;
    mq.push_back(e);
  endtask

  task automatic do_req(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] d,
                        input logic [31:0] exp_d, input int exp_stall);
    req_exp_t e;
    int       guard;
    e.is_load = rd && !wr; e.data = exp_d; e.stall = exp_stall;
    rq.push_back(e);
    @(posedge clk); #1;
    p1_addr = a; p1_wdata = d; p1_rd = rd; p1_wr = wr;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (p1_stall && guard < 200);
    if (p1_stall) fail_now($sformatf("req_timeout addr %h", a));
    @(posedge clk); #1;
    p1_rd = 1'b0; p1_wr = 1'b0;
  endtask

  task automatic ld(input logic [31:0] a, input logic [31:0] exp_d, input int exp_stall);
    do_req(a, 1'b1, 1'b0, '0, exp_d, exp_stall);
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input int exp_stall);
    do_req(a, 1'b0, 1'b1, d, '0, exp_stall);
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin : stim
    int guard;
    #12;
    chk("rst_stall", {31'b0, p1_stall}, 32'd0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_data_o", p1_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // cold miss, store/load hits, then a dirty eviction of the stored line
    exp_mem(1'b0, 32'h400, 0, '0);  ld(32'h400, 32'hA500_0400, 12);
    st(32'h404, 32'hDEAD_BEEF, 0);
    ld(32'h404, 32'hDEAD_BEEF, 0);
    exp_mem(1'b0, 32'h000, 0, '0);  ld(32'h000, 32'hA500_0000, 12);
    exp_mem(1'b1, 32'h400, 1, 32'hDEAD_BEEF);
    exp_mem(1'b0, 32'h800, 0, '0);  ld(32'h800, 32'hA500_0800, 23);

    // round-robin: third fill evicts way 0, pointer then selects way 1
    pulse_reset();
    exp_mem(1'b0, 32'h000, 0, '0);  ld(32'h000, 32'hA500_0000, 12);
    exp_mem(1'b0, 32'h400, 0, '0);  ld(32'h400, 32'hA500_0400, 12);
    ld(32'h404, 32'hDEAD_BEEF, 0);
    exp_mem(1'b0, 32'h800, 0, '0);  ld(32'h800, 32'hA500_0800, 12);
    ld(32'h400, 32'hA500_0400, 0);
    exp_mem(1'b0, 32'h000, 0, '0);  ld(32'h000, 32'hA500_0000, 12);
    ld(32'h800, 32'hA500_0800, 0);

    // dirty victim written back before the allocate read
    pulse_reset();
    exp_mem(1'b0, 32'h000, 0, '0);  st(32'h000, 32'h0000_0011, 12);
    exp_mem(1'b0, 32'h400, 0, '0);  ld(32'h400, 32'hA500_0400, 12);
    exp_mem(1'b1, 32'h000, 0, 32'h0000_0011);
    exp_mem(1'b0, 32'h1000, 0, '0); ld(32'h1000, 32'hA500_1000, 23);
    exp_mem(1'b0, 32'h000, 0, '0);  ld(32'h000, 32'h0000_0011, 12);
    ld(32'h004, 32'hA500_0001, 0);

    // read and write together behave as a store
    exp_mem(1'b0, 32'h020, 0, '0);
    do_req(32'h020, 1'b1, 1'b1, 32'h1234_5678, '0, 12);
    ld(32'h020, 32'h1234_5678, 0);

    // reset while allocating: outputs drop at once, late ack ignored, line still absent
    @(posedge clk); #1;
    p1_addr = 32'h040; p1_rd = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!mem_en && guard < 20);
    if (!mem_en) fail_now("alloc_start_timeout");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("async_rst_stall", {31'b0, p1_stall}, 32'd0);
    chk("async_rst_mem_we", {31'b0, mem_we}, 32'd0);
    p1_rd = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1 ack_late = 1'b1;
    @(posedge clk); #1 ack_late = 1'b0;
    @(negedge clk);
    chk("late_ack_mem_en", {31'b0, mem_en}, 32'd0);
    chk("late_ack_stall", {31'b0, p1_stall}, 32'd0);
    exp_mem(1'b0, 32'h040, 0, '0);  ld(32'h040, 32'hA500_0040, 12);

    repeat (4) @(negedge clk);
    chk("req_queue_drained", 32'(rq.size()), 32'd0);
    chk("mem_queue_drained", 32'(mq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dcache_assoc_ctrl.md
Name: dcache_assoc_ctrl

Overview:
Parametrised N-way set-associative, write-back, write-allocate data cache controller between the pipeline MEM stage and the 256-bit off-chip data memory. It replaces the fixed direct-mapped cache. It holds the pipeline via a stall output on misses and runs writeback/refill handshakes with memory. Victim selection is a round-robin pointer kept per set.

Parameters:
WAYS, 2, associativity; power of two, 1..4
SETS, 32, sets per way; power of two, >=2
LINE_BITS, 256, line width; equals memory bus width
ADDR_W, 32, byte address width
WORD_W, 32, CPU data width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-low reset
p1_addr_i  in  ADDR_W  CPU byte address (word aligned)
p1_data_i  in  WORD_W  CPU store data
p1_MemRead_i  in  1  load request
p1_MemWrite_i  in  1  store request
p1_data_o  out  WORD_W  load data, valid on hit cycle
p1_stall_o  out  1  pipeline hold
mem_data_i  in  LINE_BITS  refill line
mem_ack_i  in  1  one-cycle completion pulse
mem_data_o  out  LINE_BITS  writeback line
mem_addr_o  out  ADDR_W  line-aligned memory address
mem_enable_o  out  1  memory request
mem_write_o  out  1  1 = write, 0 = read

Behaviour:
- Address fields: OFF = log2(LINE_BITS/8) = 5; IDX = log2(SETS); tag = the remaining upper bits; word select = addr[OFF-1:2].
- Request = MemRead | MemWrite. If both are high, the request is treated as a write.
- Reset (rst_i low, async): all valid/dirty bits, victim pointers and outputs go to 0; state goes to IDLE. Data/tag arrays are not cleared. An in-flight memory transaction is abandoned and mem_enable_o drops immediately. A late mem_ack_i after reset is ignored.
- FSM states: IDLE, WRITEBACK, ALLOCATE, REFILL.
- IDLE, no request: p1_stall_o = 0.
- IDLE, request and hit in any way (valid & tag match): zero-latency, p1_stall_o = 0.
  - Load: p1_data_o = the selected word, combinationally in the same cycle.
  - Store: at the next posedge, write the word into the hit way and set its dirty bit.
- IDLE, request and miss: p1_stall_o = 1 combinationally. At the next edge, go to WRITEBACK if the victim is valid & dirty, else ALLOCATE.
- Victim choice: the first invalid way (lowest index); otherwise the way given by the set's round-robin pointer.
- WRITEBACK: mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {victim tag, index, 0}, mem_data_o = victim line, all held stable. On a cycle with mem_ack_i = 1, go to ALLOCATE.
- ALLOCATE: mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {req tag, index, 0}. On mem_ack_i, capture mem_data_i and go to REFILL.
- REFILL (1 cycle): write the line and tag into the victim way; valid = 1, dirty = 0. Advance that set's pointer (mod WAYS) only if the victim came from the pointer. Then go to IDLE.
- After REFILL, IDLE re-evaluates the request, which now hits; the stall drops in that cycle.
- Request inputs must stay stable while stalled. mem_enable_o goes low the cycle after the ack.
- mem_enable_o = 0 and mem_write_o = 0 in IDLE and REFILL.
- Stall is high in all non-IDLE states.
- Miss latency, clean: 1 + L_ack + 1 cycles of stall, where L_ack = cycles from enable to ack.
- Miss latency, dirty: adds a further L_ack + 1.
- mem_ack_i outside WRITEBACK/ALLOCATE is ignored.
- WAYS = 1 degenerates to direct-mapped (pointer unused).
- Non-request cycles never change any state.

Decomposition:
- Package dcache_pkg holds:
  - FSM state enum;
  - localparam functions for OFF/IDX/TAG widths;
  - the word-select/insert helper.
- One sub-module, dcache_way_array: one way's tag/valid/dirty/data storage with combinational read and synchronous write. It is instantiated WAYS times via generate. Controller and victim logic live in the top.

Test Plan:
- Cold load 0x00000400, memory ack after 10 cycles -> one ALLOCATE read at address 0x400. Stall lasts 12 cycles; p1_data_o equals memory word 0 on the release cycle.
- Store 0xDEADBEEF to 0x404, then load 0x404 -> no memory traffic. The load returns 0xDEADBEEF with stall 0; the line's dirty bit is 1.
- WAYS=2, SETS=32: load 0x0000, 0x0400 and 0x0800 (same index 0).
  - The third access evicts way 0 (the pointer).
  - Reloading 0x0400 hits, and the pointer ends at 1.
- Dirty eviction: store 0x11 to 0x0000, fill both ways, then miss on 0x1000.
  - WRITEBACK comes first: mem_write_o = 1, addr 0x0000, data word 0 = 0x11.
  - Then ALLOCATE reads 0x1000.
- MemRead and MemWrite both high at 0x20 -> handled as a store; the next load of 0x20 returns p1_data_i.
- Assert rst_i low in the middle of ALLOCATE -> mem_enable_o and stall go low asynchronously. A later ack is ignored, and re-requesting the same address misses again.
